// File: rtl/pcap_dma_pkg.sv
// rtl/pcap_dma_pkg.sv - shared flag indices, FSM states and status-word layout for the capture DMA controller
package pcap_dma_pkg;

    localparam int FLG_BLOCK  = 0;
    localparam int FLG_CAPT   = 1;
    localparam int FLG_TMO    = 2;
    localparam int FLG_DISARM = 3;
    localparam int FLG_UNDER  = 4;
    localparam int FLG_OVER   = 5;
    localparam int FLG_ARMED  = 6;
    localparam int FLG_LOST   = 7;

    localparam int ST_FLAGS_LSB = 0;
    localparam int ST_FLAGS_W   = 8;
    localparam int ST_CNT_LSB   = 16;
    localparam int ST_CNT_W     = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    function automatic logic [31:0] mk_status(input logic [ST_FLAGS_W-1:0] flags,
                                              input logic [ST_CNT_W-1:0]   cnt);
        logic [31:0] s;
        s = '0;
        s[ST_FLAGS_LSB +: ST_FLAGS_W] = flags;
        s[ST_CNT_LSB +: ST_CNT_W]     = cnt;
        return s;
    endfunction

endpackage

// File: rtl/pcap_dma_fifo.sv
// rtl/pcap_dma_fifo.sv - synchronous FIFO with level output and optional OR-merge into tail when full
module pcap_dma_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter bit MERGE = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [WIDTH-1:0]         merge_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [AW:0]      cnt_q;
    logic [AW-1:0]    tail;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             do_merge;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_MAX);
    assign tail     = wr_q - PTR_ONE;
    assign do_pop   = pop_i && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push_i && (!full || do_pop);
    assign do_merge = MERGE && push_i && full && !do_pop;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
            if (do_push) begin
                wr_q <= wr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (resetn_i) begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
            end else if (do_merge) begin
                mem_q[tail] <= mem_q[tail] | merge_i;
            end
        end
    end

    assign rdata_o = empty ? '0 : mem_q[rd_q];
    assign level_o = cnt_q;

endmodule

// File: rtl/pcap_dma_ctrl.sv
// rtl/pcap_dma_ctrl.sv - capture DMA buffer sequencer: address table, block/timeout/done handling, IRQ status queue
module pcap_dma_ctrl
    import pcap_dma_pkg::*;
#(
    parameter int ADDR_DEPTH = 32,
    parameter int SMPL_W     = 16,
    parameter int STAT_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    input  logic                          arm_i,
    input  logic                          disarm_i,
    input  logic                          addr_wr_i,
    input  logic [31:0]                   addr_i,
    input  logic [SMPL_W-1:0]             block_smpls_i,
    input  logic [31:0]                   timeout_i,
    input  logic                          sample_valid_i,
    input  logic                          pcap_done_i,
    input  logic                          irq_ack_i,
    output logic [31:0]                   dma_addr_o,
    output logic                          dma_addr_valid_o,
    output logic                          irq_o,
    output logic [31:0]                   irq_status_o,
    output logic                          armed_o,
    output logic [$clog2(ADDR_DEPTH):0]   table_level_o
);
    localparam int TLW = $clog2(ADDR_DEPTH) + 1;
    localparam int SLW = $clog2(STAT_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [SMPL_W-1:0] count_q, count_d;
    logic [SMPL_W-1:0] block_q, block_d;
    logic [31:0]       timer_q, timer_d;
    logic [31:0]       addr_q, addr_d;
    logic              vld_q, vld_d;

    logic [SMPL_W-1:0] cnt_inc;
    logic [SMPL_W-1:0] evt_cnt;
    logic [7:0]        flags;
    logic              blk_full;
    logic              tmo_hit;
    logic              tbl_pop;
    logic              tbl_empty;
    logic              tbl_full;
    logic [31:0]       tbl_head;
    logic [TLW-1:0]    tbl_level;
    logic [SLW-1:0]    stat_level;
    logic [31:0]       stat_word;
    logic [31:0]       stat_merge;

    assign tbl_empty = (tbl_level == '0);
    assign tbl_full  = (tbl_level == TLW'(ADDR_DEPTH));

    // Block size 0 wraps the SMPL_W-bit increment to 0, i.e. 2^SMPL_W words.
    assign cnt_inc  = count_q + SMPL_W'(sample_valid_i);
    assign blk_full = sample_valid_i && (cnt_inc == block_q);
    assign tmo_hit  = (timeout_i != 32'd0) && !sample_valid_i && (count_q != '0)
                      && ((timer_q + 32'd1) == timeout_i);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        block_d = block_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        tbl_pop = 1'b0;
        flags   = '0;
        evt_cnt = '0;
        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    if (!tbl_empty) begin
                        tbl_pop          = 1'b1;
                        addr_d           = tbl_head;
                        vld_d            = 1'b1;
                        count_d          = '0;
                        timer_d          = '0;
                        block_d          = block_smpls_i;
                        state_d          = ST_ACTIVE;
                        flags[FLG_ARMED] = 1'b1;
                    end else begin
                        flags[FLG_UNDER] = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                evt_cnt = cnt_inc;
                count_d = cnt_inc;
                if (sample_valid_i) begin
                    timer_d = '0;
                end else if (count_q != '0) begin
                    timer_d = timer_q + 32'd1;
                end
                if (pcap_done_i || disarm_i) begin
                    flags[FLG_CAPT]   = pcap_done_i;
                    flags[FLG_DISARM] = disarm_i;
                    flags[FLG_BLOCK]  = blk_full;
                    state_d           = ST_IDLE;
                    vld_d             = 1'b0;
                    count_d           = '0;
                    timer_d           = '0;
                end else if (blk_full || tmo_hit) begin
                    flags[FLG_BLOCK] = blk_full;
                    flags[FLG_TMO]   = tmo_hit;
                    count_d          = '0;
                    timer_d          = '0;
                    if (!tbl_empty) begin
                        tbl_pop = 1'b1;
                        addr_d  = tbl_head;
                    end else begin
                        flags[FLG_UNDER] = 1'b1;
                        vld_d            = 1'b0;
                        state_d          = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (addr_wr_i && tbl_full && !tbl_pop) begin
            flags[FLG_OVER] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            block_q <= '0;
            timer_q <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            block_q <= block_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
        end
    end

    // Events in one cycle share a single status entry; a full queue folds them into the tail.
    assign stat_word  = mk_status(flags, ST_CNT_W'(evt_cnt));
    assign stat_merge = mk_status(flags | (8'd1 << FLG_LOST), '0);

    pcap_dma_fifo #(
        .WIDTH (32),
        .DEPTH (ADDR_DEPTH),
        .MERGE (1'b0)
    ) u_addr_tbl (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push_i   (addr_wr_i),
        .wdata_i  (addr_i),
        .merge_i  (32'd0),
        .pop_i    (tbl_pop),
        .rdata_o  (tbl_head),
        .level_o  (tbl_level)
    );

    pcap_dma_fifo #(
        .WIDTH (32),
        .DEPTH (STAT_DEPTH),
        .MERGE (1'b1)
    ) u_stat_q (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push_i   (flags != 8'd0),
        .wdata_i  (stat_word),
        .merge_i  (stat_merge),
        .pop_i    (irq_ack_i),
        .rdata_o  (irq_status_o),
        .level_o  (stat_level)
    );

    assign dma_addr_o       = addr_q;
    assign dma_addr_valid_o = vld_q;
    assign armed_o          = (state_q == ST_ACTIVE);
    assign irq_o            = (stat_level != '0);
    assign table_level_o    = tbl_level;

endmodule

// File: tb/tb_pcap_dma_ctrl.sv
// tb/tb_pcap_dma_ctrl.sv - directed self-checking bench for pcap_dma_ctrl
module tb_pcap_dma_ctrl;
    localparam int ADDR_DEPTH = 32;
    localparam int SMPL_W     = 16;
    localparam int STAT_DEPTH = 4;

    logic                        clk_i = 1'b0;
    logic                        resetn_i;
    logic                        arm_i, disarm_i, addr_wr_i;
    logic [31:0]                 addr_i;
    logic [SMPL_W-1:0]           block_smpls_i;
    logic [31:0]                 timeout_i;
    logic                        sample_valid_i, pcap_done_i, irq_ack_i;
    logic [31:0]                 dma_addr_o, irq_status_o;
    logic                        dma_addr_valid_o, irq_o, armed_o;
    logic [$clog2(ADDR_DEPTH):0] table_level_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pcap_dma_ctrl #(
        .ADDR_DEPTH (ADDR_DEPTH),
        .SMPL_W     (SMPL_W),
        .STAT_DEPTH (STAT_DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .resetn_i         (resetn_i),
        .arm_i            (arm_i),
        .disarm_i         (disarm_i),
        .addr_wr_i        (addr_wr_i),
        .addr_i           (addr_i),
        .block_smpls_i    (block_smpls_i),
        .timeout_i        (timeout_i),
        .sample_valid_i   (sample_valid_i),
        .pcap_done_i      (pcap_done_i),
        .irq_ack_i        (irq_ack_i),
        .dma_addr_o       (dma_addr_o),
        .dma_addr_valid_o (dma_addr_valid_o),
        .irq_o            (irq_o),
        .irq_status_o     (irq_status_o),
        .armed_o          (armed_o),
        .table_level_o    (table_level_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        arm_i = 0; disarm_i = 0; addr_wr_i = 0; addr_i = '0;
        sample_valid_i = 0; pcap_done_i = 0; irq_ack_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        block_smpls_i = 16'd4;
        timeout_i = '0;
        resetn_i = 0;
        step();
        step();
        resetn_i = 1;
    endtask

    task automatic push_addr(input logic [31:0] a);
        addr_wr_i = 1; addr_i = a;
        step();
        addr_wr_i = 0;
    endtask

    task automatic pulse_arm();
        arm_i = 1;
        step();
        arm_i = 0;
    endtask

    task automatic pulse_ack();
        irq_ack_i = 1;
        step();
        irq_ack_i = 0;
    endtask

    task automatic samples(input int n);
        sample_valid_i = 1;
        for (int i = 0; i < n; i++) step();
        sample_valid_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (armed_o !== 1'b0) begin errors++; $display("FAIL reset_armed got %0b exp 0", armed_o); end
        checks++; if (dma_addr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", dma_addr_valid_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b exp 0", irq_o); end
        checks++; if (irq_status_o !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", irq_status_o); end
        checks++; if (table_level_o !== 6'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", table_level_o); end
        checks++; if (dma_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", dma_addr_o); end
    endtask

    task automatic test_blocks();
        do_reset();
        push_addr(32'hA000_0000);
        push_addr(32'hA000_1000);
        push_addr(32'hA000_2000);
        checks++; if (table_level_o !== 6'd3) begin errors++; $display("FAIL blk_level3 got %0d exp 3", table_level_o); end
        pulse_arm();
        checks++; if (armed_o !== 1'b1) begin errors++; $display("FAIL blk_armed got %0b exp 1", armed_o); end
        checks++; if (dma_addr_o !== 32'hA000_0000) begin errors++; $display("FAIL blk_addr0 got %h exp a0000000", dma_addr_o); end
        checks++; if (irq_status_o !== 32'h0000_0040) begin errors++; $display("FAIL blk_arm_status got %h exp 00000040", irq_status_o); end
        checks++; if (table_level_o !== 6'd2) begin errors++; $display("FAIL blk_level2 got %0d exp 2", table_level_o); end
        pulse_ack();
        samples(3);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL blk_no_irq_early got %0b exp 0", irq_o); end
        samples(1);
        checks++; if (dma_addr_o !== 32'hA000_1000) begin errors++; $display("FAIL blk_addr1 got %h exp a0001000", dma_addr_o); end
        samples(4);
        checks++; if (dma_addr_o !== 32'hA000_2000) begin errors++; $display("FAIL blk_addr2 got %h exp a0002000", dma_addr_o); end
        checks++; if (irq_status_o !== 32'h0004_0001) begin errors++; $display("FAIL blk_status1 got %h exp 00040001", irq_status_o); end
        pulse_ack();
        checks++; if (irq_status_o !== 32'h0004_0001) begin errors++; $display("FAIL blk_status2 got %h exp 00040001", irq_status_o); end
        pulse_ack();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL blk_drained got %0b exp 0", irq_o); end
        checks++; if (armed_o !== 1'b1) begin errors++; $display("FAIL blk_still_armed got %0b exp 1", armed_o); end
    endtask

    task automatic test_last_block();
        do_reset();
        push_addr(32'hB000_0000);
        pulse_arm();
        pulse_ack();
        samples(4);
        checks++; if (irq_status_o !== 32'h0004_0011) begin errors++; $display("FAIL last_status got %h exp 00040011", irq_status_o); end
        checks++; if (armed_o !== 1'b0) begin errors++; $display("FAIL last_armed got %0b exp 0", armed_o); end
        checks++; if (dma_addr_valid_o !== 1'b0) begin errors++; $display("FAIL last_valid got %0b exp 0", dma_addr_valid_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        timeout_i = 32'd10;
        push_addr(32'hC000_0000);
        push_addr(32'hC000_1000);
        pulse_arm();
        pulse_ack();
        samples(2);
        for (int i = 0; i < 9; i++) step();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL tmo_early got %0b exp 0", irq_o); end
        step();
        checks++; if (irq_status_o !== 32'h0002_0004) begin errors++; $display("FAIL tmo_status got %h exp 00020004", irq_status_o); end
        checks++; if (dma_addr_o !== 32'hC000_1000) begin errors++; $display("FAIL tmo_addr got %h exp c0001000", dma_addr_o); end
        checks++; if (armed_o !== 1'b1) begin errors++; $display("FAIL tmo_armed got %0b exp 1", armed_o); end
        pulse_ack();
        for (int i = 0; i < 15; i++) step();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL tmo_no_refire got %0b exp 0", irq_o); end
        timeout_i = '0;
    endtask

    task automatic test_stat_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) pulse_arm();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL sov_irq got %0b exp 1", irq_o); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (irq_status_o !== 32'h0000_0010) begin errors++; $display("FAIL sov_entry%0d got %h exp 00000010", i, irq_status_o); end
            pulse_ack();
        end
        checks++; if (irq_status_o !== 32'h0000_0090) begin errors++; $display("FAIL sov_tail got %h exp 00000090", irq_status_o); end
        pulse_ack();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL sov_drained got %0b exp 0", irq_o); end
        pulse_ack();
        checks++; if (irq_status_o !== 32'h0) begin errors++; $display("FAIL sov_empty_ack got %h exp 0", irq_status_o); end
    endtask

    task automatic test_table_overflow();
        do_reset();
        addr_wr_i = 1;
        for (int i = 0; i <= ADDR_DEPTH; i++) begin
            addr_i = 32'h1000_0000 + i;
            step();
        end
        addr_wr_i = 0;
        checks++; if (table_level_o !== 6'd32) begin errors++; $display("FAIL tov_level got %0d exp 32", table_level_o); end
        checks++; if (irq_status_o !== 32'h0000_0020) begin errors++; $display("FAIL tov_status got %h exp 00000020", irq_status_o); end
        pulse_ack();
        arm_i = 1; addr_wr_i = 1; addr_i = 32'h2000_0000;
        step();
        arm_i = 0; addr_wr_i = 0;
        checks++; if (table_level_o !== 6'd32) begin errors++; $display("FAIL tov_pop_push_level got %0d exp 32", table_level_o); end
        checks++; if (irq_status_o !== 32'h0000_0040) begin errors++; $display("FAIL tov_pop_push_status got %h exp 00000040", irq_status_o); end
        checks++; if (dma_addr_o !== 32'h1000_0000) begin errors++; $display("FAIL tov_addr got %h exp 10000000", dma_addr_o); end
        samples(1);
        resetn_i = 0; arm_i = 1; sample_valid_i = 1; addr_wr_i = 1; pcap_done_i = 1; irq_ack_i = 1;
        step();
        clear_inputs();
        checks++; if ({armed_o, dma_addr_valid_o, irq_o} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got %b exp 000", {armed_o, dma_addr_valid_o, irq_o}); end
        checks++; if (dma_addr_o !== 32'h0 || irq_status_o !== 32'h0) begin errors++; $display("FAIL rst_mid_data got %h/%h exp 0/0", dma_addr_o, irq_status_o); end
        checks++; if (table_level_o !== 6'd0) begin errors++; $display("FAIL rst_mid_level got %0d exp 0", table_level_o); end
        resetn_i = 1;
        step();
    endtask

    task automatic test_done_partial();
        do_reset();
        push_addr(32'hD000_0000);
        push_addr(32'hD000_1000);
        pulse_arm();
        pulse_ack();
        samples(2);
        sample_valid_i = 1; pcap_done_i = 1;
        step();
        sample_valid_i = 0; pcap_done_i = 0;
        checks++; if (irq_status_o !== 32'h0003_0002) begin errors++; $display("FAIL done_part_status got %h exp 00030002", irq_status_o); end
        checks++; if ({armed_o, dma_addr_valid_o} !== 2'b00) begin errors++; $display("FAIL done_part_state got %b exp 00", {armed_o, dma_addr_valid_o}); end
        checks++; if (table_level_o !== 6'd1) begin errors++; $display("FAIL done_part_level got %0d exp 1", table_level_o); end
        pulse_ack();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL done_part_single got %0b exp 0", irq_o); end
    endtask

    task automatic test_done_full();
        do_reset();
        push_addr(32'hE000_0000);
        push_addr(32'hE000_1000);
        pulse_arm();
        pulse_ack();
        samples(3);
        sample_valid_i = 1; pcap_done_i = 1;
        step();
        sample_valid_i = 0; pcap_done_i = 0;
        checks++; if (irq_status_o !== 32'h0004_0003) begin errors++; $display("FAIL done_full_status got %h exp 00040003", irq_status_o); end
        checks++; if (table_level_o !== 6'd1) begin errors++; $display("FAIL done_full_no_pop got %0d exp 1", table_level_o); end
        pulse_ack();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL done_full_single got %0b exp 0", irq_o); end
    endtask

    task automatic test_disarm();
        do_reset();
        push_addr(32'hF000_0000);
        pulse_arm();
        pulse_ack();
        samples(1);
        disarm_i = 1; pcap_done_i = 1;
        step();
        disarm_i = 0; pcap_done_i = 0;
        checks++; if (irq_status_o !== 32'h0001_000A) begin errors++; $display("FAIL disarm_status got %h exp 0001000a", irq_status_o); end
        checks++; if (armed_o !== 1'b0) begin errors++; $display("FAIL disarm_armed got %0b exp 0", armed_o); end
        pulse_ack();
        disarm_i = 1;
        step();
        disarm_i = 0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL disarm_idle_ignored got %0b exp 0", irq_o); end
    endtask

    initial begin
        test_reset();
        test_blocks();
        test_last_block();
        test_timeout();
        test_stat_overflow();
        test_table_overflow();
        test_done_partial();
        test_done_full();
        test_disarm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcap_dma_ctrl.md
PCAP_DMA_CTRL -- requirements
Module: pcap_dma_ctrl

Interface
REQ-001 SHALL have parameter ADDR_DEPTH, default 32, address-table entries (power of 2).
REQ-002 SHALL have parameter SMPL_W, default 16, sample-count width.
REQ-003 SHALL have parameter STAT_DEPTH, default 4, IRQ status queue entries (power of 2).
REQ-004 SHALL have port clk_i  in  1  sole clock; one clock domain.
REQ-005 SHALL have port resetn_i  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports arm_i, disarm_i  in  1 each  single-cycle arm/disarm pulses.
REQ-007 SHALL have ports addr_wr_i in 1, addr_i in 32  push buffer base address into table.
REQ-008 SHALL have port block_smpls_i  in  SMPL_W  words per buffer, sampled at arm.
REQ-009 SHALL have port timeout_i  in  32  idle cycles before partial flush; 0 disables.
REQ-010 SHALL have ports sample_valid_i, pcap_done_i  in  1 each  DMA word accepted; capture ended.
REQ-011 SHALL have port irq_ack_i  in  1  pops status queue head.
REQ-012 SHALL have ports dma_addr_o out 32, dma_addr_valid_o out 1  active buffer base.
REQ-013 SHALL have ports irq_o out 1, irq_status_o out 32  [7:0] flags, [15:8] zero, [31:16] sample count (zero-extended).
REQ-014 SHALL have ports armed_o out 1, table_level_o out $clog2(ADDR_DEPTH)+1.

Function
REQ-015 Flags SHALL be: b0 block done, b1 capture done, b2 timeout flush, b3 disarmed, b4 table underrun, b5 table overflow, b6 armed, b7 status lost.
REQ-016 FSM SHALL have states IDLE and ACTIVE; armed_o = (state==ACTIVE).
REQ-017 IDLE + arm_i + table non-empty SHALL pop head to dma_addr_o, set dma_addr_valid_o, clear count, go ACTIVE, push status b6 next cycle.
REQ-018 IDLE + arm_i + table empty SHALL stay IDLE and push status b4.
REQ-019 arm_i in ACTIVE SHALL be ignored; disarm_i in IDLE SHALL be ignored.
REQ-020 In ACTIVE, each sample_valid_i SHALL increment count by 1.
REQ-021 block_smpls_i value 0 SHALL mean 2^SMPL_W words.
REQ-022 Sample making count equal block size SHALL push {count, b0} and pop next address, both visible the following cycle; table empty -> also b4, clear dma_addr_valid_o, go IDLE.
REQ-023 pcap_done_i in ACTIVE SHALL push {count incl. same-cycle sample, b1}, clear dma_addr_valid_o, go IDLE.
REQ-024 disarm_i in ACTIVE SHALL push {count, b3}, go IDLE; with pcap_done_i same cycle push b1|b3 once.
REQ-025 Block-full and pcap_done_i in the same cycle SHALL push one entry b0|b1, no address pop.
REQ-026 Timeout counter SHALL clear on each sample_valid_i, count while ACTIVE and count>0; on reaching timeout_i SHALL push {count, b2} and advance buffer per REQ-022.
REQ-027 addr_wr_i with table full SHALL drop address and push b5; full with same-cycle pop SHALL accept.
REQ-028 irq_o SHALL equal status queue non-empty; irq_status_o = head, zero when empty.
REQ-029 irq_ack_i SHALL pop head; ack on empty queue ignored.
REQ-030 Push to full queue SHALL OR new flags plus b7 into tail entry, tail count unchanged; simultaneous ack+push SHALL accept.
REQ-031 Count SHALL not wrap; SMPL_W-bit arithmetic, block size caps it.

Reset
REQ-032 resetn_i low at a clk_i edge SHALL force IDLE, empty both FIFOs, clear count and timer, all outputs 0, mid-operation included.
REQ-033 Inputs SHALL be ignored during the reset cycle.

Structure
REQ-034 Package pcap_dma_pkg SHALL hold flag bit indices, FSM state enum, status-field offsets.
REQ-035 Address table and status queue SHALL each instantiate one synchronous FIFO sub-module pcap_dma_fifo (parametrised width/depth, level output).

Verification
REQ-036 Push 3 addrs, block_smpls=4, arm, 8 samples -> statuses 0x00000040, 0x00040001, 0x00040001; dma_addr_o steps addr0->addr1->addr2.
REQ-037 Push 1 addr, block_smpls=4, arm, 4 samples -> 0x00040011, armed_o=0, dma_addr_valid_o=0.
REQ-038 timeout_i=10, 2 samples then idle -> at 10th idle cycle status 0x00020004, buffer advances.
REQ-039 STAT_DEPTH=4, no acks, 6 events -> irq_o=1, tail entry has b7 set, acks drain exactly 4.
REQ-040 ADDR_DEPTH+1 writes -> table_level_o=ADDR_DEPTH, status b5; reset mid-ACTIVE -> all outputs 0 next cycle.
REQ-041 pcap_done_i with final sample, count 3 of 4 -> single status 0x00030002.
